// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Turns the PS/2 receiver byte stream into key events. It handles
//            E0/F0 prefixes, make/break and typematic repeat. It tracks the
//            Shift, Ctrl and CapsLock state, maps the key to ASCII and counts
//            distinct non-modifier presses.
// Ports    : clk          system clock (posedge)
//            clr          asynchronous reset, active low
//            code         scan-code byte from the receiver
//            code_valid   one-cycle strobe qualifying code
//            key_code     scan code of the last event (prefixes stripped)
//            key_ext      last event carried an E0 prefix
//            key_down     a non-modifier key is currently held
//            key_repeat   last event was a typematic repeat
//            event_valid  one-cycle pulse when the key_* / ascii outputs update
//            ascii        ASCII of key_code, 0x00 if unmapped or extended
//            press_count  distinct non-modifier presses, wraps at 2^CNT_W
//            shift, ctrl, caps  modifier state
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       code,
  input  logic             code_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_repeat,
  output logic             event_valid,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_count,
  output logic             shift,
  output logic             ctrl,
  output logic             caps
);

  localparam int TOUT_W = $clog2(TIMEOUT + 1);

  // Bit 0 = E0 seen, bit 1 = F0 seen.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_EXT     = 2'b01;
  localparam logic [1:0] ST_BRK     = 2'b10;
  localparam logic [1:0] ST_EXT_BRK = 2'b11;

  localparam logic [7:0] C_E0 = 8'hE0;
  localparam logic [7:0] C_F0 = 8'hF0;

  logic [1:0]        r_state;
  logic [TOUT_W-1:0] r_tcnt;
  logic              r_held_vld;
  logic [8:0]        r_held;      // {ext, code} of the held key
  logic              r_caps_held; // suppresses Caps toggling on typematic repeat

  logic       w_ext;
  logic       w_brk;
  logic       w_is_shift;
  logic       w_is_ctrl;
  logic       w_is_caps;
  logic [8:0] w_key;
  logic       w_match;
  logic [7:0] w_ascii;

  // Letters return upper/lower case. Digits, space and enter do not depend on
  // the case selector.
  function automatic logic [7:0] f_ascii(input logic [7:0] sc, input logic upper);
    logic [7:0] lc;
    logic [7:0] other;
    lc    = 8'h00;
    other = 8'h00;
    case (sc)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      8'h45: other = "0"; 8'h16: other = "1"; 8'h1E: other = "2";
      8'h26: other = "3"; 8'h25: other = "4"; 8'h2E: other = "5";
      8'h36: other = "6"; 8'h3D: other = "7"; 8'h3E: other = "8";
      8'h46: other = "9";
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      default: begin
        lc    = 8'h00;
        other = 8'h00;
      end
    endcase
    if (lc != 8'h00) begin
      return upper ? (lc - 8'h20) : lc;
    end
    return other;
  endfunction

  assign w_ext      = r_state[0];
  assign w_brk      = r_state[1];
  assign w_is_shift = !w_ext && ((code == 8'h12) || (code == 8'h59));
  assign w_is_ctrl  = (code == 8'h14);
  assign w_is_caps  = !w_ext && (code == 8'h58);
  assign w_key      = {w_ext, code};
  assign w_match    = r_held_vld && (r_held == w_key);
  // Uses the modifier state from before this byte.
  assign w_ascii    = w_ext ? 8'h00 : f_ascii(code, shift ^ caps);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= ST_IDLE;
      r_tcnt      <= '0;
      r_held_vld  <= 1'b0;
      r_held      <= '0;
      r_caps_held <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      key_repeat  <= 1'b0;
      event_valid <= 1'b0;
      ascii       <= '0;
      press_count <= '0;
      shift       <= 1'b0;
      ctrl        <= 1'b0;
      caps        <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      if (code_valid) begin
        r_tcnt <= '0;
        if (code == C_E0) begin
          r_state <= w_brk ? ST_EXT_BRK : ST_EXT;
        end else if (code == C_F0) begin
          r_state <= w_ext ? ST_EXT_BRK : ST_BRK;
        end else begin
          r_state <= ST_IDLE;
          if (w_is_shift) begin
            shift <= !w_brk;
          end else if (w_is_ctrl) begin
            ctrl <= !w_brk;
          end else if (w_is_caps) begin
            if (w_brk) begin
              r_caps_held <= 1'b0;
            end else begin
              if (!r_caps_held) begin
                caps <= !caps;
              end
              r_caps_held <= 1'b1;
            end
          end else begin
            event_valid <= 1'b1;
            key_code    <= code;
            key_ext     <= w_ext;
            ascii       <= w_ascii;
            if (!w_brk) begin
              if (w_match) begin
                key_repeat <= 1'b1;
              end else begin
                key_repeat  <= 1'b0;
                key_down    <= 1'b1;
                r_held      <= w_key;
                r_held_vld  <= 1'b1;
                press_count <= press_count + 1'b1;
              end
            end else begin
              key_repeat <= 1'b0;
              // A break for a key other than the held one leaves key_down alone.
              if (w_match) begin
                key_down   <= 1'b0;
                r_held_vld <= 1'b0;
              end
            end
          end
        end
      end else if (r_state != ST_IDLE) begin
        // Abandon a dangling prefix so a lost byte cannot corrupt the next key.
        if (r_tcnt == TOUT_W'(TIMEOUT - 1)) begin
          r_state <= ST_IDLE;
          r_tcnt  <= '0;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Self-checking bench for ps2_key_decoder. Expected key events are
//            queued as stimulus is driven. Each DUT event pulse pops one entry
//            and compares it against the DUT outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             clr;
  logic [7:0]       code;
  logic             code_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_down;
  logic             key_repeat;
  logic             event_valid;
  logic [7:0]       ascii;
  logic [CNT_W-1:0] press_count;
  logic             shift;
  logic             ctrl;
  logic             caps;

  typedef struct packed {
    logic [7:0]       kc;
    logic             ext;
    logic             rep;
    logic [7:0]       asc;
    logic             down;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  ev_t              exp_q[$];
  int               n_total;
  int               n_pass;
  logic [CNT_W-1:0] exp_cnt;

  ps2_key_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clr        (clr),
    .code       (code),
    .code_valid (code_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_down   (key_down),
    .key_repeat (key_repeat),
    .event_valid(event_valid),
    .ascii      (ascii),
    .press_count(press_count),
    .shift      (shift),
    .ctrl       (ctrl),
    .caps       (caps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare each event pulse against the oldest expectation.
  always @(negedge clk) begin
    if (event_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got key_code=%h ext=%b rep=%b ascii=%h down=%b cnt=%0d, none expected",
                 key_code, key_ext, key_repeat, ascii, key_down, press_count);
      end else begin
        ev_t e;
        ev_t got;
        e   = exp_q.pop_front();
        got = '{kc: key_code, ext: key_ext, rep: key_repeat, asc: ascii,
                down: key_down, cnt: press_count};
        if (got !== e) begin
          $display("FAIL event: got code=%h ext=%b rep=%b ascii=%h down=%b cnt=%0d, want code=%h ext=%b rep=%b ascii=%h down=%b cnt=%0d",
                   got.kc, got.ext, got.rep, got.asc, got.down, got.cnt,
                   e.kc, e.ext, e.rep, e.asc, e.down, e.cnt);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge, after the byte is taken.
  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  function automatic void expect_ev(input logic [7:0] kc, input logic ext, input logic rep,
                                    input logic [7:0] asc, input logic down);
    exp_q.push_back('{kc: kc, ext: ext, rep: rep, asc: asc, down: down, cnt: exp_cnt});
  endfunction

  task automatic test_reset();
    clr        = 1'b0;
    code       = 8'h00;
    code_valid = 1'b0;
    exp_cnt    = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({key_code, key_ext, key_down, key_repeat, event_valid, ascii, press_count, shift, ctrl, caps} !== '0) begin
      $display("FAIL reset_state: outputs not all zero (code=%h down=%b cnt=%0d)", key_code, key_down, press_count);
    end else begin
      n_pass++;
    end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make_repeat();
    exp_cnt++;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1);
    send(8'h1C);
    @(negedge clk);
    n_total++;
    if (event_valid !== 1'b0) begin
      $display("FAIL pulse_width: event_valid=%b, want 0 on the second cycle", event_valid);
    end else begin
      n_pass++;
    end
    expect_ev(8'h1C, 1'b0, 1'b1, 8'h61, 1'b1);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b1, 8'h61, 1'b1);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b0);
    send(8'hF0);
    send(8'h1C);
  endtask

  task automatic test_modifiers();
    send(8'h12);
    n_total++;
    if (shift !== 1'b1) $display("FAIL shift_make: shift=%b want 1", shift);
    else n_pass++;
    exp_cnt++;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41, 1'b1);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41, 1'b0);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    n_total++;
    if (shift !== 1'b0) $display("FAIL shift_break: shift=%b want 0", shift);
    else n_pass++;
    send(8'h58);
    n_total++;
    if (caps !== 1'b1) $display("FAIL caps_on: caps=%b want 1", caps);
    else n_pass++;
    send(8'hF0);
    send(8'h58);
    exp_cnt++;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41, 1'b1);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h41, 1'b0);
    send(8'hF0);
    send(8'h1C);
    // Shift with caps cancels back to lower case.
    send(8'h12);
    exp_cnt++;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b0);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    // A held Caps key repeating must not toggle again.
    send(8'h58);
    send(8'h58);
    send(8'h58);
    n_total++;
    if (caps !== 1'b0) $display("FAIL caps_repeat: caps=%b want 0", caps);
    else n_pass++;
    send(8'hF0);
    send(8'h58);
  endtask

  task automatic test_extended();
    exp_cnt++;
    expect_ev(8'h75, 1'b1, 1'b0, 8'h00, 1'b1);
    send(8'hE0);
    send(8'h75);
    expect_ev(8'h75, 1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'h14);
    n_total++;
    if (ctrl !== 1'b1) $display("FAIL ctrl_ext_make: ctrl=%b want 1", ctrl);
    else n_pass++;
    send(8'hE0);
    send(8'hF0);
    send(8'h14);
    n_total++;
    if (ctrl !== 1'b0) $display("FAIL ctrl_ext_break: ctrl=%b want 0", ctrl);
    else n_pass++;
  endtask

  task automatic test_misc_keys();
    exp_cnt++;
    expect_ev(8'h45, 1'b0, 1'b0, 8'h30, 1'b1);
    send(8'h45);
    exp_cnt++;
    expect_ev(8'h16, 1'b0, 1'b0, 8'h31, 1'b1);
    send(8'h16);
    expect_ev(8'h16, 1'b0, 1'b0, 8'h31, 1'b0);
    send(8'hF0);
    send(8'h16);
    exp_cnt++;
    expect_ev(8'h29, 1'b0, 1'b0, 8'h20, 1'b1);
    send(8'h29);
    exp_cnt++;
    expect_ev(8'h5A, 1'b0, 1'b0, 8'h0D, 1'b1);
    send(8'h5A);
    // Releasing a key that is no longer the held one keeps key_down.
    expect_ev(8'h29, 1'b0, 1'b0, 8'h20, 1'b1);
    send(8'hF0);
    send(8'h29);
    expect_ev(8'h5A, 1'b0, 1'b0, 8'h0D, 1'b0);
    send(8'hF0);
    send(8'h5A);
  endtask

  task automatic test_timeout();
    exp_cnt++;
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1);
    send(8'hF0);
    repeat (TIMEOUT) @(negedge clk);
    send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b0);
    send(8'hF0);
    repeat (TIMEOUT - 1) @(negedge clk);
    send(8'h1C);
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 256; i++) begin
      exp_cnt++;
      if (i % 2 == 0) begin
        expect_ev(8'h1C, 1'b0, 1'b0, 8'h61, 1'b1);
        send(8'h1C);
      end else begin
        expect_ev(8'h32, 1'b0, 1'b0, 8'h62, 1'b1);
        send(8'h32);
      end
    end
    n_total++;
    if (press_count !== exp_cnt) $display("FAIL wrap_count: press_count=%0d want %0d", press_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sequence();
    send(8'hE0);
    send(8'hF0);
    #3;
    clr = 1'b0;
    #1;
    n_total++;
    if ({key_code, key_ext, key_down, key_repeat, event_valid, ascii, press_count, shift, ctrl, caps} !== '0) begin
      $display("FAIL async_reset: outputs not zero (code=%h down=%b cnt=%0d)", key_code, key_down, press_count);
    end else begin
      n_pass++;
    end
    exp_cnt = '0;
    @(negedge clk);
    code       = 8'h1C;
    code_valid = 1'b1;
    repeat (2) @(negedge clk);
    code_valid = 1'b0;
    n_total++;
    if ({key_down, press_count, event_valid} !== '0) begin
      $display("FAIL valid_in_reset: down=%b cnt=%0d ev=%b want all 0", key_down, press_count, event_valid);
    end else begin
      n_pass++;
    end
    clr = 1'b1;
    @(negedge clk);
    exp_cnt++;
    expect_ev(8'h75, 1'b0, 1'b0, 8'h00, 1'b1);
    send(8'h75);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_make_repeat();
    test_modifiers();
    test_extended();
    test_misc_keys();
    test_timeout();
    test_back_to_back_wrap();
    test_reset_mid_sequence();
    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
